// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: FSM state type and RV32I funct3 encodings shared by the LSU files.
package load_store_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-side request/response and data-memory bus signals of the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// load_align: selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    data = funct3[1] ? word :
           (funct3[1:0] == F3_H[1:0]) ? {{16{~funct3[2] & h[15]}}, h} :
           {{24{~funct3[2] & b[7]}}, b};
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store stage, one access outstanding over a valid/ready memory bus.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of issuing them.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  lsu_state_t  state, nxt;
  logic        write, err, misal, load_done, fault, req_phase;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, load_data, st_data;
  logic [3:0]  st_be;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misal = (bus.req_funct3[1:0] == F3_H[1:0] && bus.req_addr[0]) ||
                 (bus.req_funct3[1] && bus.req_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  load_align u_align (.funct3(funct3), .addr(addr[1:0]), .word(bus.mem_rdata), .data(load_data));
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) nxt = misal ? RESP : REQ;
      REQ:     if (bus.mem_ready) nxt = (write || bus.mem_rvalid) ? RESP : WAIT;
      WAIT:    if (bus.mem_rvalid) nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  assign load_done = !write && bus.mem_rvalid && ((state == REQ && bus.mem_ready) || state == WAIT);
  assign fault = state == IDLE && bus.req_valid && misal;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      write  <= 1'b0;
      funct3 <= '0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      state <= nxt;
      rdata <= load_done ? load_data : '0;
      err   <= fault;
      if (state == IDLE && bus.req_valid) begin
        write  <= bus.req_write;
        funct3 <= bus.req_funct3;
        addr   <= bus.req_addr;
        wdata  <= bus.req_wdata;
      end
    end
  end
  // Halfword lane follows addr[1] so unchecked misaligned halfwords stay inside the word.
  assign st_be = funct3[1] ? 4'hF : funct3[0] ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr[1:0];
  assign st_data = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  assign req_phase = state == REQ;
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
  assign bus.mem_valid = req_phase;
  assign bus.mem_we    = req_phase && write;
  assign bus.mem_addr  = req_phase ? {addr[31:2], 2'b00} : '0;
  assign bus.mem_be    = !req_phase ? 4'h0 : write ? st_be : 4'hF;
  assign bus.mem_wdata = (req_phase && write) ? st_data : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors with a cycle-level memory responder.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  load_store_unit_if bus();
  load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic access(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, wd, rd, input int rdy, rv, lat,
                        input logic bus_exp, input logic [31:0] maddr, input logic [3:0] be,
                        input logic [31:0] mwd, exd, input logic er);
    int cyc, acc, nmv;
    logic got, bad;
    chk({tag, " ready0"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1; acc = -1; nmv = 0; got = 1'b0; bad = 1'b0;
    while (!got && cyc < 20) begin
      bad |= bus.req_ready;
      if (acc < 0 && bus.mem_valid) begin
        if (nmv == 0) begin
          chk({tag, " maddr"}, bus.mem_addr, maddr);
          chk({tag, " be"}, {28'h0, bus.mem_be}, {28'h0, be});
          chk({tag, " we"}, {31'h0, bus.mem_we}, {31'h0, w});
          if (w) chk({tag, " mwdata"}, bus.mem_wdata, mwd);
        end else bad |= (bus.mem_addr !== maddr);
        bus.mem_ready = (nmv == rdy);
        if (bus.mem_ready) acc = cyc;
        nmv++;
      end else begin
        bus.mem_ready = 1'b0;
        bad |= bus.mem_valid;
      end
      bus.mem_rvalid = !w && ((acc >= 0 && cyc - acc == rv) || (acc < 0 && bus.mem_valid && !bus.mem_ready));
      bus.mem_rdata = (acc >= 0) ? rd : 32'hBAD0BAD0;
      if (bus.rsp_valid) begin
        got = 1'b1;
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " rdata"}, bus.rsp_rdata, exd);
        chk({tag, " err"}, {31'h0, bus.rsp_err}, {31'h0, er});
      end else bad |= (bus.rsp_rdata !== 32'h0) || (bus.rsp_err !== 1'b0);
      @(posedge clk); #1;
      cyc++;
      bus.mem_ready = 1'b0;
      bus.mem_rvalid = 1'b0;
    end
    chk({tag, " rsp seen"}, {31'h0, got}, 32'h1);
    chk({tag, " protocol"}, {31'h0, bad}, 32'h0);
    chk({tag, " bus used"}, {31'h0, nmv > 0}, {31'h0, bus_exp});
    chk({tag, " ready after"}, {31'h0, bus.req_ready}, 32'h1);
    chk({tag, " single pulse"}, {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst rsp", {bus.rsp_valid, bus.rsp_err, bus.mem_valid, bus.mem_we, bus.mem_be}, 32'h0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;
    access("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 2, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0);
    access("sb", 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, 2, 1, 32'h200, 4'h8, 32'hA5A5A5A5, 0, 0);
    access("sh", 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 0, 0, 2, 1, 32'h100, 4'hC, 32'hBEEFBEEF, 0, 0);
    access("lb", 0, 3'b000, 32'h101, 0, 32'h1234F6AA, 0, 1, 3, 1, 32'h100, 4'hF, 0, 32'hFFFFFFF6, 0);
    access("lbu", 0, 3'b100, 32'h101, 0, 32'h1234F6AA, 0, 1, 3, 1, 32'h100, 4'hF, 0, 32'h000000F6, 0);
    access("lhu", 0, 3'b101, 32'h102, 0, 32'h1234F6AA, 0, 1, 3, 1, 32'h100, 4'hF, 0, 32'h00001234, 0);
    access("lh", 0, 3'b001, 32'h100, 0, 32'h1234F6AA, 0, 0, 2, 1, 32'h100, 4'hF, 0, 32'hFFFFF6AA, 0);
    access("lw slow", 0, 3'b010, 32'h100, 0, 32'h1234F6AA, 3, 2, 7, 1, 32'h100, 4'hF, 0, 32'h1234F6AA, 0);
    access("lb b3", 0, 3'b000, 32'h103, 0, 32'h80000000, 0, 1, 3, 1, 32'h100, 4'hF, 0, 32'hFFFFFF80, 0);
    access("f3 111", 0, 3'b111, 32'h104, 0, 32'hCAFEF00D, 0, 1, 3, 1, 32'h104, 4'hF, 0, 32'hCAFEF00D, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    access("lw mis", 0, 3'b010, 32'h102, 0, 32'h1234F6AA, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    access("sh mis", 1, 3'b001, 32'h101, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
`else
    access("lw mis", 0, 3'b010, 32'h102, 0, 32'h1234F6AA, 0, 1, 3, 1, 32'h100, 4'hF, 0, 32'h1234F6AA, 0);
    access("sh mis", 1, 3'b001, 32'h101, 32'h1234, 0, 0, 0, 2, 1, 32'h100, 4'h3, 32'h12341234, 0, 0);
`endif
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h300;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("wait mem_valid", {31'h0, bus.mem_valid}, 32'h0);
    chk("wait req_ready", {31'h0, bus.req_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55555555;
    chk("abort req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("abort outs", {bus.rsp_valid, bus.rsp_err, bus.mem_valid, bus.mem_we, bus.mem_be}, 32'h0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    chk("late rvalid rsp", {31'h0, bus.rsp_valid}, 32'h0);
    chk("late rvalid rdata", bus.rsp_rdata, 32'h0);
    chk("late rvalid ready", {31'h0, bus.req_ready}, 32'h1);
    access("after rst", 1, 3'b010, 32'h40, 32'h01020304, 0, 0, 0, 2, 1, 32'h40, 4'hF, 32'h01020304, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
